// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction fetch engine feeding the instruction fetch buffer (IFB).
// It holds the fetch PC, requests 8-byte I-cache lines, picks the 32-bit
// instruction selected by PC[2], and forms the next PC from the branch
// predictor. Each fetched instruction is stored in a one-entry output
// register and pushed into the IFB from there.
//
// Optional build macro: IF_PERF_CNT_EN adds two 32-bit performance counters
// (pushes and full-stall cycles). Without the macro those ports are absent.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   ifb_full_i           IFB full, a push is not allowed while high
//   flush_en_i           mispredict flush, overrides everything else
//   flush_target_PC_i    redirect PC, valid with flush_en_i
//   bp_pred_taken_i      predictor result for the PC on proc2Icache_addr_o
//   bp_target_PC_i       predicted target, valid when bp_pred_taken_i=1
//   Icache_valid_i       Icache_data_i is valid for the current request
//   Icache_data_i        8-byte cache line
//   proc2Icache_req_o    fetch request
//   proc2Icache_addr_o   line address {PC[63:3],3'b000}
//   ifb_en_o             IFB push
//   if_insn_o            pushed instruction
//   if_PC_o              PC of the pushed instruction
//   if_target_PC_o       predicted next PC of the pushed instruction
//   if_pred_bit_o        predicted-taken bit of the pushed instruction
//   if_fetch_cnt_o       (IF_PERF_CNT_EN) number of pushes, wraps at 2^32
//   if_stall_cnt_o       (IF_PERF_CNT_EN) cycles with a held entry and IFB full
//
// Handshake: the I-cache request is a level. proc2Icache_addr_o stays
// constant while proc2Icache_req_o is high and Icache_valid_i is low; the
// line is consumed in the cycle where both are high. The IFB push is a
// single-cycle strobe, and the IFB must accept it whenever ifb_full_i is low.
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] HALT_INSN = 32'h0000_0555
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifb_full_i,
    input  logic        flush_en_i,
    input  logic [63:0] flush_target_PC_i,
    input  logic        bp_pred_taken_i,
    input  logic [63:0] bp_target_PC_i,
    input  logic        Icache_valid_i,
    input  logic [63:0] Icache_data_i,
    output logic        proc2Icache_req_o,
    output logic [63:0] proc2Icache_addr_o,
    output logic        ifb_en_o,
    output logic [31:0] if_insn_o,
    output logic [63:0] if_PC_o,
    output logic [63:0] if_target_PC_o,
    output logic        if_pred_bit_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] if_fetch_cnt_o,
    output logic [31:0] if_stall_cnt_o
`endif
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HALT  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [63:0] r_pc;
    logic        r_out_valid;
    logic [31:0] r_out_insn;
    logic [63:0] r_out_pc;
    logic [63:0] r_out_target;
    logic        r_out_pred;

    logic        w_req;
    logic        w_ifb_en;
    logic        w_capture;
    logic [31:0] w_insn;
    logic [63:0] w_next_pc;
    logic        w_unused_bits;

    // Low PC bits are forced to zero on every load, so these inputs are
    // intentionally ignored.
    assign w_unused_bits = ^{flush_target_PC_i[1:0], bp_target_PC_i[1:0]};

    // Instruction select and next-PC formation for the line being returned.
    assign w_insn    = r_pc[2] ? Icache_data_i[63:32] : Icache_data_i[31:0];
    assign w_next_pc = bp_pred_taken_i ? {bp_target_PC_i[63:2], 2'b00}
                                       : (r_pc + 64'd4);
    assign w_capture = w_req & Icache_valid_i;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        if (flush_en_i) begin
            w_state_next = S_FETCH;
        end else if (w_capture && (w_insn == HALT_INSN)) begin
            w_state_next = S_HALT;
        end
    end

    // ---------------- FSM: outputs ----------------
    // A new request is only useful if the output register will be free at
    // the next edge: either it is empty or it is being pushed right now.
    // Reset gates both strobes so a response arriving during reset is ignored.
    always_comb begin
        w_ifb_en = 1'b0;
        w_req    = 1'b0;
        if (!rst) begin
            w_ifb_en = r_out_valid & ~ifb_full_i & ~flush_en_i;
            w_req    = (r_state == S_FETCH) & ~flush_en_i &
                       (~r_out_valid | w_ifb_en);
        end
    end

    // ---------------- PC and output register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= {RESET_PC[63:2], 2'b00};
            r_out_valid  <= 1'b0;
            r_out_insn   <= '0;
            r_out_pc     <= '0;
            r_out_target <= '0;
            r_out_pred   <= 1'b0;
        end else if (flush_en_i) begin
            // The held entry belongs to the wrong path; drop it unpushed.
            r_pc        <= {flush_target_PC_i[63:2], 2'b00};
            r_out_valid <= 1'b0;
        end else if (w_capture) begin
            r_pc         <= w_next_pc;
            r_out_valid  <= 1'b1;
            r_out_insn   <= w_insn;
            r_out_pc     <= r_pc;
            r_out_target <= w_next_pc;
            r_out_pred   <= bp_pred_taken_i;
        end else if (w_ifb_en) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    // Counters ignore flush on purpose: they measure the whole run.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_ifb_en) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (r_out_valid && ifb_full_i) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign if_fetch_cnt_o = r_fetch_cnt;
    assign if_stall_cnt_o = r_stall_cnt;
`endif

    assign proc2Icache_req_o  = w_req;
    assign proc2Icache_addr_o = {r_pc[63:3], 3'b000};
    assign ifb_en_o           = w_ifb_en;
    assign if_insn_o          = r_out_insn;
    assign if_PC_o            = r_out_pc;
    assign if_target_PC_o     = r_out_target;
    assign if_pred_bit_o      = r_out_pred;

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Directed bench for if_fetch_unit. Inputs are driven just after the falling
// edge and outputs are observed 1 ns later, so every check sees the state
// left by the previous rising edge plus the combinational response to the
// inputs of the current cycle. The I-cache is a small line array indexed by
// the request address. Expected values are written out by hand per step.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        ifb_full_i;
    logic        flush_en_i;
    logic [63:0] flush_target_PC_i;
    logic        bp_pred_taken_i;
    logic [63:0] bp_target_PC_i;
    logic        Icache_valid_i;
    logic [63:0] Icache_data_i;
    logic        proc2Icache_req_o;
    logic [63:0] proc2Icache_addr_o;
    logic        ifb_en_o;
    logic [31:0] if_insn_o;
    logic [63:0] if_PC_o;
    logic [63:0] if_target_PC_o;
    logic        if_pred_bit_o;
`ifdef IF_PERF_CNT_EN
    logic [31:0] if_fetch_cnt_o;
    logic [31:0] if_stall_cnt_o;
`endif

    int compared;
    int mismatched;

    logic [63:0] mem [0:63];

    if_fetch_unit dut (
        .clk                (clk),
        .rst                (rst),
        .ifb_full_i         (ifb_full_i),
        .flush_en_i         (flush_en_i),
        .flush_target_PC_i  (flush_target_PC_i),
        .bp_pred_taken_i    (bp_pred_taken_i),
        .bp_target_PC_i     (bp_target_PC_i),
        .Icache_valid_i     (Icache_valid_i),
        .Icache_data_i      (Icache_data_i),
        .proc2Icache_req_o  (proc2Icache_req_o),
        .proc2Icache_addr_o (proc2Icache_addr_o),
        .ifb_en_o           (ifb_en_o),
        .if_insn_o          (if_insn_o),
        .if_PC_o            (if_PC_o),
        .if_target_PC_o     (if_target_PC_o),
        .if_pred_bit_o      (if_pred_bit_o)
`ifdef IF_PERF_CNT_EN
        ,
        .if_fetch_cnt_o     (if_fetch_cnt_o),
        .if_stall_cnt_o     (if_stall_cnt_o)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- I-cache line model ----------------
    always_comb Icache_data_i = mem[proc2Icache_addr_o[8:3]];

    // ---------------- check helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_req(input string tag, input logic req, input logic [63:0] addr);
        chk({tag, ".req"}, {63'd0, proc2Icache_req_o}, {63'd0, req});
        if (req) chk({tag, ".addr"}, proc2Icache_addr_o, addr);
    endtask

    task automatic chk_push(input string tag, input logic en, input logic [31:0] insn,
                            input logic [63:0] pc, input logic [63:0] tgt, input logic pred);
        chk({tag, ".en"}, {63'd0, ifb_en_o}, {63'd0, en});
        chk({tag, ".insn"}, {32'd0, if_insn_o}, {32'd0, insn});
        chk({tag, ".pc"}, if_PC_o, pc);
        chk({tag, ".tgt"}, if_target_PC_o, tgt);
        chk({tag, ".pred"}, {63'd0, if_pred_bit_o}, {63'd0, pred});
    endtask

    task automatic chk_nopush(input string tag);
        chk({tag, ".en"}, {63'd0, ifb_en_o}, 64'd0);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        compared   = 0;
        mismatched = 0;
        for (int i = 0; i < 64; i++) mem[i] = 64'hDEAD_BEEF_DEAD_BEEF;
        mem[6'h00] = 64'h1111_1111_2222_2222;  // PC 0x00 / 0x04
        mem[6'h01] = 64'h4444_4444_3333_3333;  // PC 0x08 / 0x0C
        mem[6'h02] = 64'h6666_6666_5555_5555;  // PC 0x10 / 0x14
        mem[6'h04] = 64'hBBBB_BBBB_0000_0555;  // PC 0x20 holds HALT
        mem[6'h08] = 64'h8888_8888_7777_7777;  // PC 0x40 / 0x44
        mem[6'h20] = 64'hAAAA_AAAA_9999_9999;  // PC 0x100 / 0x104
        mem[6'h3F] = 64'hCCCC_CCCC_DDDD_DDDD;  // PC ..F8 / ..FC

        rst               = 1'b1;
        ifb_full_i        = 1'b0;
        flush_en_i        = 1'b0;
        flush_target_PC_i = 64'h0;
        bp_pred_taken_i   = 1'b0;
        bp_target_PC_i    = 64'h0;
        Icache_valid_i    = 1'b1;

        // Reset: all outputs quiet, address at RESET_PC.
        tick(); tick(); settle();
        chk("rst.req", {63'd0, proc2Icache_req_o}, 64'd0);
        chk("rst.addr", proc2Icache_addr_o, 64'h0);
        chk_push("rst", 1'b0, 32'h0, 64'h0, 64'h0, 1'b0);

        // Cycle A: first request, nothing to push yet.
        tick(); rst = 1'b0; settle();
        chk_req("A", 1'b1, 64'h0);
        chk_nopush("A");

        // Cycle B: push PC 0, request still on line 0 for PC 4.
        tick(); settle();
        chk_req("B", 1'b1, 64'h0);
        chk_push("B", 1'b1, 32'h2222_2222, 64'h0, 64'h4, 1'b0);

        // Cycle C: push PC 4, miss begins at PC 8.
        tick(); Icache_valid_i = 1'b0; settle();
        chk_req("C", 1'b1, 64'h8);
        chk_push("C", 1'b1, 32'h1111_1111, 64'h4, 64'h8, 1'b0);

        // Cycles D, E: miss continues.
        tick(); settle();
        chk_req("D", 1'b1, 64'h8);
        chk_nopush("D");
        tick(); settle();
        chk_req("E", 1'b1, 64'h8);
        chk_nopush("E");

        // Cycle F: line returns.
        tick(); Icache_valid_i = 1'b1; settle();
        chk_req("F", 1'b1, 64'h8);
        chk_nopush("F");

        // Cycles G..K: IFB full, PC 8 entry held, no request.
        for (int k = 0; k < 5; k++) begin
            tick(); ifb_full_i = 1'b1; settle();
            chk("full.req", {63'd0, proc2Icache_req_o}, 64'd0);
            chk_push("full", 1'b0, 32'h3333_3333, 64'h8, 64'hC, 1'b0);
        end

        // Cycle L: full drops, push PC 8 once, fetch PC 0xC.
        tick(); ifb_full_i = 1'b0; settle();
        chk_req("L", 1'b1, 64'h8);
        chk_push("L", 1'b1, 32'h3333_3333, 64'h8, 64'hC, 1'b0);

        // Cycle M: push PC 0xC; predictor says PC 0x10 jumps to 0x40.
        tick(); bp_pred_taken_i = 1'b1; bp_target_PC_i = 64'h40; settle();
        chk_req("M", 1'b1, 64'h10);
        chk_push("M", 1'b1, 32'h4444_4444, 64'hC, 64'h10, 1'b0);

        // Cycle N: predicted entry pushed, request at 0x40.
        tick(); bp_pred_taken_i = 1'b0; settle();
        chk_req("N", 1'b1, 64'h40);
        chk_push("N", 1'b1, 32'h5555_5555, 64'h10, 64'h40, 1'b1);

        // Cycle O: held PC 0x40 entry, miss and flush to 0x103.
        tick(); Icache_valid_i = 1'b0; flush_en_i = 1'b1; flush_target_PC_i = 64'h103; settle();
        chk("O.req", {63'd0, proc2Icache_req_o}, 64'd0);
        chk_nopush("O");

        // Cycle P: stale entry gone, fetch 0x100.
        tick(); flush_en_i = 1'b0; Icache_valid_i = 1'b1; settle();
        chk_req("P", 1'b1, 64'h100);
        chk_nopush("P");

        // Cycle Q: push PC 0x100; predict PC 0x104 jumps to 0x20.
        tick(); bp_pred_taken_i = 1'b1; bp_target_PC_i = 64'h20; settle();
        chk_req("Q", 1'b1, 64'h100);
        chk_push("Q", 1'b1, 32'h9999_9999, 64'h100, 64'h104, 1'b0);

        // Cycle R: push PC 0x104, fetch HALT at 0x20.
        tick(); bp_pred_taken_i = 1'b0; settle();
        chk_req("R", 1'b1, 64'h20);
        chk_push("R", 1'b1, 32'hAAAA_AAAA, 64'h104, 64'h20, 1'b1);

        // Cycle S: HALT pushed, no further request.
        tick(); settle();
        chk("S.req", {63'd0, proc2Icache_req_o}, 64'd0);
        chk_push("S", 1'b1, 32'h0000_0555, 64'h20, 64'h24, 1'b0);

        for (int k = 0; k < 4; k++) begin
            tick(); settle();
            chk("halt.req", {63'd0, proc2Icache_req_o}, 64'd0);
            chk_nopush("halt");
        end

        // Flush to 0 leaves HALT.
        tick(); flush_en_i = 1'b1; flush_target_PC_i = 64'h0; settle();
        chk("hflush.req", {63'd0, proc2Icache_req_o}, 64'd0);
        chk_nopush("hflush");
        tick(); flush_en_i = 1'b0; settle();
        chk_req("resume", 1'b1, 64'h0);
        chk_nopush("resume");
        tick(); settle();
        chk_push("resume", 1'b1, 32'h2222_2222, 64'h0, 64'h4, 1'b0);

`ifdef IF_PERF_CNT_EN
        chk("perf.fetch", {32'd0, if_fetch_cnt_o}, 64'd8);
        chk("perf.stall", {32'd0, if_stall_cnt_o}, 64'd5);
`endif

        // Flush to the last word of the address space; PC+4 wraps to 0.
        tick(); flush_en_i = 1'b1; flush_target_PC_i = 64'hFFFF_FFFF_FFFF_FFFC; settle();
        chk_nopush("wflush");
        tick(); flush_en_i = 1'b0; settle();
        chk_req("wrap", 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
        tick(); settle();
        chk_req("wrap2", 1'b1, 64'h0);
        chk_push("wrap", 1'b1, 32'hCCCC_CCCC, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1'b0);

        // Reset in the middle of a miss.
        tick(); Icache_valid_i = 1'b0; settle();
        chk_req("mmiss", 1'b1, 64'h0);
        tick(); rst = 1'b1; Icache_valid_i = 1'b1; settle();
        chk("mrst.req", {63'd0, proc2Icache_req_o}, 64'd0);
        tick(); rst = 1'b0; settle();
        chk_req("mrst", 1'b1, 64'h0);
        chk_push("mrst", 1'b0, 32'h0, 64'h0, 64'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
